siso_frame_ctrl: RTL and testbench

//  Sequencer for the serial-in/serial-out shift register used as a delay line.

---
 rtl/siso_ctrl_pkg.sv | 14 +
 rtl/siso_bit_counter.sv | 28 ++
 rtl/siso_frame_ctrl.sv | 112 +++++++++++
 tb/tb_siso_frame_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/siso_ctrl_pkg.sv
// Shared definitions for the SISO delay-line frame controller: state encoding
// and the counter width helper.
package siso_ctrl_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    // Counter must reach WIDTH+DEPTH-1 without wrapping.
    function automatic int cnt_width(input int width, input int depth);
        return $clog2(width + depth + 1);
    endfunction

endpackage

// File: rtl/siso_bit_counter.sv
// Saturating up-counter with synchronous clear and a terminal-count flag at a
// programmable limit.
module siso_bit_counter #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          enable,
    input  logic [CW-1:0] limit,
    output logic [CW-1:0] count,
    output logic          at_limit
);

    assign at_limit = (count == limit);

    // Holds at the limit so the count can never wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !at_limit) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/siso_frame_ctrl.sv
// Loopback sequencer for a SISO delay line: serializes a word MSB-first, flushes
// DEPTH zeros, captures the word emerging at the far end and flags a match.
module siso_frame_ctrl
    import siso_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             sr_shift_en,
    output logic             sr_din,
    input  logic             sr_dout,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_match,
    input  logic             out_ready,
    output logic             busy
);

    localparam int            CW      = cnt_width(WIDTH, DEPTH);
    localparam logic [CW-1:0] LIMIT   = CW'(WIDTH + DEPTH - 1);
    localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CW-1:0]    cnt;
    logic             at_limit;
    logic             accept;
    logic [WIDTH-1:0] tx_buf;
    logic [WIDTH-1:0] rx_buf;
    logic [WIDTH-1:0] ref_buf;

    assign accept = (state == S_IDLE) && in_valid;

    siso_bit_counter #(
        .CW(CW)
    ) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .clear    (accept),
        .enable   (state == S_SHIFT),
        .limit    (LIMIT),
        .count    (cnt),
        .at_limit (at_limit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (in_valid)  state_nxt = S_SHIFT;
            S_SHIFT: if (at_limit)  state_nxt = S_DONE;
            S_DONE:  if (out_ready) state_nxt = S_IDLE;
            default:                state_nxt = S_IDLE;
        endcase
    end

    // Every output is decoded from registered state only.
    always_comb begin
        in_ready    = 1'b0;
        sr_shift_en = 1'b0;
        sr_din      = 1'b0;
        out_valid   = 1'b0;
        out_match   = 1'b0;
        case (state)
            S_IDLE: in_ready = 1'b1;
            S_SHIFT: begin
                sr_shift_en = 1'b1;
                sr_din      = (cnt < WIDTH_C) ? tx_buf[WIDTH-1] : 1'b0;
            end
            S_DONE: begin
                out_valid = 1'b1;
                out_match = (rx_buf == ref_buf);
            end
            default: ;
        endcase
    end

    assign busy     = (state != S_IDLE);
    assign out_data = rx_buf;

    // Bits leaving the SISO lag sr_din by DEPTH shifts, so capture starts at cnt==DEPTH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_buf  <= '0;
            rx_buf  <= '0;
            ref_buf <= '0;
        end else if (accept) begin
            tx_buf  <= in_data;
            ref_buf <= in_data;
            rx_buf  <= '0;
        end else if (state == S_SHIFT) begin
            tx_buf <= tx_buf << 1;
            if (cnt >= DEPTH_C) begin
                rx_buf <= (rx_buf << 1) | WIDTH'(sr_dout);
            end
        end
    end

endmodule

// File: tb/tb_siso_frame_ctrl.sv
// Loopback bench: drives siso_frame_ctrl against a behavioural DEPTH-stage SISO
// and checks frames against words predicted from the serial protocol.
module tb_siso_frame_ctrl;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int NSH   = WIDTH + DEPTH;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_ready;
    logic             sr_shift_en;
    logic             sr_din;
    logic             sr_dout;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_match;
    logic             out_ready = 1'b0;
    logic             busy;

    int total = 0;
    int bad   = 0;

    logic [DEPTH-1:0] siso = '0;
    logic [DEPTH-1:0] siso_nxt;
    logic             stuck2 = 1'b0;

    siso_frame_ctrl #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .sr_shift_en (sr_shift_en),
        .sr_din      (sr_din),
        .sr_dout     (sr_dout),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_match   (out_match),
        .out_ready   (out_ready),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Behavioural SISO: stage 0 at the input, registered output from the last stage.
    always @(posedge clk) begin
        if (sr_shift_en) begin
            siso_nxt = {siso[DEPTH-2:0], sr_din};
            if (stuck2) siso_nxt[2] = 1'b0;
            siso <= siso_nxt;
        end
    end
    assign sr_dout = siso[DEPTH-1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers a word in IDLE and returns just after the accepting edge.
    task automatic start_frame(input logic [WIDTH-1:0] w);
        in_valid = 1'b1;
        in_data  = w;
        check("ready_before_accept", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check("busy_after_accept", {31'd0, busy}, 32'd1);
    endtask

    // Follows a frame until out_valid, checking the serial stream and the latency
    // counted from the accepting edge (inclusive).
    task automatic wait_done(input logic [WIDTH-1:0] w, input logic [WIDTH-1:0] exp_data);
        int          lat;
        int          nshift;
        logic [31:0] seq;
        lat    = 1;
        nshift = 0;
        seq    = '0;
        while (out_valid !== 1'b1 && lat < 60) begin
            if (sr_shift_en === 1'b1) begin
                seq = {seq[30:0], sr_din};
                nshift++;
            end
            tick();
            lat++;
        end
        check("latency", lat, NSH + 1);
        check("shift_count", nshift, NSH);
        check("sr_din_seq", seq, {24'd0, w} << DEPTH);
        check("out_data", {24'd0, out_data}, {24'd0, exp_data});
        check("out_match", {31'd0, out_match}, {31'd0, exp_data == w});
        check("done_ctrl", {29'd0, in_ready, sr_shift_en, busy}, 32'b001);
    endtask

    task automatic release_done();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("idle_after_done", {29'd0, out_valid, in_ready, busy}, 32'b010);
    endtask

    initial begin
        logic [WIDTH-1:0] w;
        logic [WIDTH-1:0] held;
        int               d;

        // 1. reset held low, then released
        repeat (5) tick();
        check("reset_outputs", {28'd0, out_valid, sr_shift_en, busy, out_match}, 32'd0);
        check("reset_data", {24'd0, out_data}, 32'd0);
        reset = 1'b1;
        tick();
        check("post_reset", {28'd0, in_ready, busy, out_valid, sr_shift_en}, 32'b1000);

        // 2. single frame 0xA5
        start_frame(8'hA5);
        wait_done(8'hA5, 8'hA5);
        release_done();

        // 3. back-to-back 0xFF then 0x00 with out_ready tied high
        out_ready = 1'b1;
        start_frame(8'hFF);
        wait_done(8'hFF, 8'hFF);
        in_valid = 1'b1;
        in_data  = 8'h00;
        tick();
        check("b2b_idle_gap", {29'd0, in_ready, busy, out_valid}, 32'b100);
        start_frame(8'h00);
        wait_done(8'h00, 8'h00);
        tick();
        out_ready = 1'b0;
        check("b2b_end_idle", {30'd0, in_ready, busy}, 32'b10);

        // 4. stuck-at-0 on SISO stage 2 zeroes everything that reaches the output
        stuck2 = 1'b1;
        start_frame(8'h3C);
        wait_done(8'h3C, 8'h00);
        stuck2 = 1'b0;
        release_done();

        // 5. DONE held for 20 cycles with a pending word
        w = WIDTH'($urandom_range(1, 255));
        start_frame(w);
        wait_done(w, w);
        held     = out_data;
        in_valid = 1'b1;
        in_data  = ~w;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("hold_done", {21'd0, out_valid, out_match, in_ready, busy, out_data},
                  {21'd0, 1'b1, 1'b1, 1'b0, 1'b1, held});
        end
        in_valid  = 1'b0;
        release_done();

        // randomized frames with random consumer back-pressure
        for (int n = 0; n < 6; n++) begin
            w = WIDTH'($urandom_range(0, 255));
            d = $urandom_range(0, 3);
            start_frame(w);
            wait_done(w, w);
            repeat (d) tick();
            check("rand_hold", {23'd0, out_valid, out_data}, {23'd0, 1'b1, w});
            release_done();
        end

        // 6. asynchronous reset at cnt=6 of frame 0x81, then a clean 0x5A frame
        start_frame(8'h81);
        repeat (6) tick();
        #2;
        reset = 1'b0;
        #1;
        check("async_reset", {27'd0, out_valid, sr_shift_en, sr_din, busy, out_match}, 32'd0);
        check("async_reset_data", {24'd0, out_data}, 32'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("ready_after_rst", {30'd0, in_ready, busy}, 32'b10);
        start_frame(8'h5A);
        wait_done(8'h5A, 8'h5A);
        release_done();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
